// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard scan-code decoder: FSM encoding,
// prefix byte values, frame geometry and the parity helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] EXT_PREFIX   = 8'hE0;

   // start + 8 data + parity + stop
   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = FRAME_BITS - 3;

   // Odd parity holds when data plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data lines into the system clock domain and
// flags each falling edge of the keyboard clock as a one-cycle fall_evt.
module ps2_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic fall_evt,
   output logic dat_sync
);

   logic clk_meta_r;
   logic clk_sync_r;
   logic clk_prev_r;
   logic dat_meta_r;
   logic dat_sync_r;

   // Two-flop synchronizers plus one history flop on the clock line; all idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_meta_r <= 1'b1;
         clk_sync_r <= 1'b1;
         clk_prev_r <= 1'b1;
         dat_meta_r <= 1'b1;
         dat_sync_r <= 1'b1;
      end else begin
         clk_meta_r <= ps2_clk;
         clk_sync_r <= clk_meta_r;
         clk_prev_r <= clk_sync_r;
         dat_meta_r <= ps2_dat;
         dat_sync_r <= dat_meta_r;
      end
   end

   assign fall_evt = clk_prev_r & ~clk_sync_r;
   assign dat_sync = dat_sync_r;

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: frames bytes off the keyboard lines, strips the
// F0/E0 prefixes and reports each key code with make/break and extended flags.
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] keyboard_code,
   output logic       makeBreak,
   output logic       extended,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int             TO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
   localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

   logic            fall_evt_s;
   logic            dat_sync_s;
   logic            timeout_hit_s;

   ps2_state_e      state_r,       state_next_s;
   logic [2:0]      bit_cnt_r,     bit_cnt_next_s;
   logic [7:0]      shift_r,       shift_next_s;
   logic            parity_ok_r,   parity_ok_next_s;
   logic            brk_r,         brk_next_s;
   logic            ext_r,         ext_next_s;
   logic [TO_W-1:0] timeout_cnt_r, timeout_cnt_next_s;
   logic [7:0]      code_r,        code_next_s;
   logic            make_r,        make_next_s;
   logic            extended_r,    extended_next_s;
   logic            valid_r,       valid_next_s;
   logic            err_r,         err_next_s;

   ps2_sync_edge u_sync_edge (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_dat  (ps2_dat),
      .fall_evt (fall_evt_s),
      .dat_sync (dat_sync_s)
   );

   assign timeout_hit_s = (timeout_cnt_r >= TO_LIMIT);

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         bit_cnt_r     <= 3'd0;
         shift_r       <= 8'h00;
         parity_ok_r   <= 1'b0;
         brk_r         <= 1'b0;
         ext_r         <= 1'b0;
         timeout_cnt_r <= {TO_W{1'b0}};
         code_r        <= 8'h00;
         make_r        <= 1'b0;
         extended_r    <= 1'b0;
         valid_r       <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         bit_cnt_r     <= bit_cnt_next_s;
         shift_r       <= shift_next_s;
         parity_ok_r   <= parity_ok_next_s;
         brk_r         <= brk_next_s;
         ext_r         <= ext_next_s;
         timeout_cnt_r <= timeout_cnt_next_s;
         code_r        <= code_next_s;
         make_r        <= make_next_s;
         extended_r    <= extended_next_s;
         valid_r       <= valid_next_s;
         err_r         <= err_next_s;
      end
   end

   // Frame FSM, prefix tracking and timeout supervision.
   always_comb begin
      state_next_s     = state_r;
      bit_cnt_next_s   = bit_cnt_r;
      shift_next_s     = shift_r;
      parity_ok_next_s = parity_ok_r;
      brk_next_s       = brk_r;
      ext_next_s       = ext_r;
      code_next_s      = code_r;
      make_next_s      = make_r;
      extended_next_s  = extended_r;
      valid_next_s     = 1'b0;
      err_next_s       = 1'b0;

      if (fall_evt_s || (state_r == IDLE)) begin
         timeout_cnt_next_s = {TO_W{1'b0}};
      end else begin
         timeout_cnt_next_s = timeout_cnt_r + TO_W'(1);
      end

      case (state_r)
         IDLE: begin
            if (fall_evt_s && !dat_sync_s) begin
               state_next_s   = DATA;
               bit_cnt_next_s = 3'd0;
            end else begin
               state_next_s = IDLE;
            end
         end

         DATA: begin
            if (fall_evt_s) begin
               shift_next_s = {dat_sync_s, shift_r[7:1]};
               if (bit_cnt_r == LAST_BIT) begin
                  state_next_s = PARITY;
               end else begin
                  bit_cnt_next_s = bit_cnt_r + 3'd1;
               end
            end else if (timeout_hit_s) begin
               state_next_s = IDLE;
               err_next_s   = 1'b1;
               brk_next_s   = 1'b0;
               ext_next_s   = 1'b0;
            end else begin
               state_next_s = DATA;
            end
         end

         PARITY: begin
            if (fall_evt_s) begin
               parity_ok_next_s = odd_parity_ok(shift_r, dat_sync_s);
               state_next_s     = STOP;
            end else if (timeout_hit_s) begin
               state_next_s = IDLE;
               err_next_s   = 1'b1;
               brk_next_s   = 1'b0;
               ext_next_s   = 1'b0;
            end else begin
               state_next_s = PARITY;
            end
         end

         STOP: begin
            if (fall_evt_s) begin
               state_next_s = IDLE;
               if (dat_sync_s && parity_ok_r) begin
                  if (shift_r == BREAK_PREFIX) begin
                     brk_next_s = 1'b1;
                  end else if (shift_r == EXT_PREFIX) begin
                     ext_next_s = 1'b1;
                  end else begin
                     code_next_s     = shift_r;
                     make_next_s     = ~brk_r;
                     extended_next_s = ext_r;
                     valid_next_s    = 1'b1;
                     brk_next_s      = 1'b0;
                     ext_next_s      = 1'b0;
                  end
               end else begin
                  err_next_s = 1'b1;
                  brk_next_s = 1'b0;
                  ext_next_s = 1'b0;
               end
            end else if (timeout_hit_s) begin
               state_next_s = IDLE;
               err_next_s   = 1'b1;
               brk_next_s   = 1'b0;
               ext_next_s   = 1'b0;
            end else begin
               state_next_s = STOP;
            end
         end

         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   assign keyboard_code = code_r;
   assign makeBreak     = make_r;
   assign extended      = extended_r;
   assign code_valid    = valid_r;
   assign frame_err     = err_r;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed self-checking bench for ps2_scan_decoder: drives keyboard frames
// bit by bit and compares the decoded outputs against hand-computed values.
module tb_ps2_scan_decoder;

   localparam int HALF = 10;   // system clocks per PS/2 clock half-period

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [7:0] keyboard_code;
   logic       makeBreak;
   logic       extended;
   logic       code_valid;
   logic       frame_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_fall_cyc = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   int both_cnt  = 0;
   int valid_lat = 0;
   int err_lat   = 0;
   int v0;
   int e0;

   ps2_scan_decoder #(.TIMEOUT_CYCLES(50000)) dut (
      .clk           (clk),
      .rst           (rst),
      .ps2_clk       (ps2_clk),
      .ps2_dat       (ps2_dat),
      .keyboard_code (keyboard_code),
      .makeBreak     (makeBreak),
      .extended      (extended),
      .code_valid    (code_valid),
      .frame_err     (frame_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (code_valid) begin
         valid_cnt = valid_cnt + 1;
         valid_lat = cyc - last_fall_cyc;
      end
      if (frame_err) begin
         err_cnt = err_cnt + 1;
         err_lat = cyc - last_fall_cyc;
      end
      if (code_valid && frame_err) both_cnt = both_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ps2_send(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_dat = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         last_fall_cyc = cyc;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic flip_par);
      logic [10:0] bits;
      bits = {1'b1, (~^data) ^ flip_par, data, 1'b0};
      ps2_send(bits, 11);
      ps2_dat = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_code",  {24'd0, keyboard_code}, 32'h00);
      check_eq("rst_make",  {31'd0, makeBreak},     32'd0);
      check_eq("rst_ext",   {31'd0, extended},      32'd0);
      check_eq("rst_valid", {31'd0, code_valid},    32'd0);
      check_eq("rst_err",   {31'd0, frame_err},     32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Plain make code
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h1C, 1'b0);
      check_eq("1c_pulses", valid_cnt - v0, 32'd1);
      check_eq("1c_code",   {24'd0, keyboard_code}, 32'h1C);
      check_eq("1c_make",   {31'd0, makeBreak},     32'd1);
      check_eq("1c_ext",    {31'd0, extended},      32'd0);
      check_eq("1c_noerr",  err_cnt - e0,           32'd0);
      check_eq("1c_latency_le4", {31'd0, (valid_lat <= 4)}, 32'd1);

      // Break sequence F0 1C
      v0 = valid_cnt;
      send_frame(8'hF0, 1'b0);
      check_eq("f0_no_pulse", valid_cnt - v0, 32'd0);
      send_frame(8'h1C, 1'b0);
      check_eq("brk_pulses", valid_cnt - v0, 32'd1);
      check_eq("brk_code",   {24'd0, keyboard_code}, 32'h1C);
      check_eq("brk_make",   {31'd0, makeBreak},     32'd0);
      check_eq("brk_ext",    {31'd0, extended},      32'd0);

      // Extended make E0 5A, then ordinary 29
      v0 = valid_cnt;
      send_frame(8'hE0, 1'b0);
      send_frame(8'h5A, 1'b0);
      check_eq("e0_pulses", valid_cnt - v0, 32'd1);
      check_eq("e0_code",   {24'd0, keyboard_code}, 32'h5A);
      check_eq("e0_make",   {31'd0, makeBreak},     32'd1);
      check_eq("e0_ext",    {31'd0, extended},      32'd1);
      send_frame(8'h29, 1'b0);
      check_eq("29_code",   {24'd0, keyboard_code}, 32'h29);
      check_eq("29_ext",    {31'd0, extended},      32'd0);

      // Extended break E0 F0 75: both prefixes survive to the key byte
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check_eq("e0f0_code", {24'd0, keyboard_code}, 32'h75);
      check_eq("e0f0_make", {31'd0, makeBreak},     32'd0);
      check_eq("e0f0_ext",  {31'd0, extended},      32'd1);

      // Parity error
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h29, 1'b1);
      check_eq("par_err",    err_cnt - e0,   32'd1);
      check_eq("par_novalid", valid_cnt - v0, 32'd0);
      check_eq("par_code",   {24'd0, keyboard_code}, 32'h75);

      // Timeout: start bit + 4 data bits then silence
      v0 = valid_cnt; e0 = err_cnt;
      ps2_send(11'b000_0000_1010, 5);
      ps2_dat = 1'b1;
      repeat (60000) @(negedge clk);
      check_eq("to_err",     err_cnt - e0,   32'd1);
      check_eq("to_novalid", valid_cnt - v0, 32'd0);
      check_eq("to_at_limit", {31'd0, (err_lat >= 50000) && (err_lat <= 50006)}, 32'd1);
      send_frame(8'h16, 1'b0);
      check_eq("after_to_code", {24'd0, keyboard_code}, 32'h16);
      check_eq("after_to_make", {31'd0, makeBreak},     32'd1);

      // Reset in mid-frame
      ps2_send(11'b000_0001_1100, 5);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_code",  {24'd0, keyboard_code}, 32'h00);
      check_eq("mid_rst_make",  {31'd0, makeBreak},     32'd0);
      check_eq("mid_rst_ext",   {31'd0, extended},      32'd0);
      check_eq("mid_rst_valid", {31'd0, code_valid},    32'd0);
      check_eq("mid_rst_err",   {31'd0, frame_err},     32'd0);
      ps2_dat = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'h1E, 1'b0);
      check_eq("post_rst_pulses", valid_cnt - v0, 32'd1);
      check_eq("post_rst_code",   {24'd0, keyboard_code}, 32'h1E);
      check_eq("post_rst_make",   {31'd0, makeBreak},     32'd1);
      check_eq("post_rst_noerr",  err_cnt - e0,           32'd0);

      check_eq("never_both", both_cnt, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
